ring_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters, using a one-hot rotating priority pointer (ring counter) to pick the winner. It sits between the requesting blocks and the shared resource. It issues one registered one-hot grant at a time and holds it until the grantee signals `done`, drops its request, or exceeds a hold-time limit. After each grant, priority rotates to the requester just after the previous winner, which guarantees starvation-free service.

---
 rtl/ring_arbiter_pkg.sv | 25 ++
 rtl/ring_arbiter_pick.sv | 49 ++++
 rtl/ring_arbiter.sv | 117 +++++++++++
 tb/tb_ring_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ring_arbiter_pkg.sv
// Shared definitions for the round-robin ring arbiter: state encoding,
// default sizing and a constant-evaluable clog2.
package ring_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 16;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ring_arbiter_pick.sv
// Combinational round-robin winner selection: first set request at or above
// the one-hot pointer, wrapping modulo N, via a double-width masked scan.
module rr_pick
    import ring_arbiter_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          ptr,
    output logic [N-1:0]          winner,
    output logic [clog2(N)-1:0]   index,
    output logic                  found
);

    localparam int IW = clog2(N);
    localparam int W2 = 2 * N;
    localparam logic [N-1:0]  ONE_N  = N'(1);
    localparam logic [W2-1:0] ONE_W2 = W2'(1);

    logic          ptr_ok;
    logic [N-1:0]  ptr_eff;
    logic [W2-1:0] req2;
    logic [W2-1:0] mask2;
    logic [W2-1:0] masked;
    int            sel;
    int            idx;

    always_comb begin
        // A corrupted (non one-hot) pointer falls back to starting at bit 0.
        ptr_ok  = (ptr != '0) && ((ptr & (ptr - ONE_N)) == '0);
        ptr_eff = ptr_ok ? ptr : ONE_N;
        req2    = {req, req};
        // Lower copy is masked below the pointer; upper copy supplies the wrap.
        mask2   = ~({{N{1'b0}}, ptr_eff} - ONE_W2);
        masked  = req2 & mask2;
        found   = 1'b0;
        sel     = 0;
        for (int j = W2 - 1; j >= 0; j--) begin
            if (masked[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
        idx    = (sel >= N) ? (sel - N) : sel;
        index  = idx[IW-1:0];
        winner = found ? (ONE_N << idx) : '0;
    end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority pointer; grants are
// registered and held until done, request withdrawal, or the hold limit.
module ring_arbiter
    import ring_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic                done,
    output logic [N-1:0]        grant,
    output logic [clog2(N)-1:0] grant_id,
    output logic                busy,
    output logic                timeout
);

    localparam int IW = clog2(N);
    localparam int HW = clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [N-1:0]  PTR_INIT = N'(1);

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [N-1:0]  ptr_q;
    logic [N-1:0]  ptr_d;
    logic [N-1:0]  grant_d;
    logic [IW-1:0] id_d;
    logic          busy_d;
    logic          timeout_d;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          release_req;
    logic          limit_hit;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_onehot),
        .index  (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ptr_d       = ptr_q;
        grant_d     = grant;
        id_d        = grant_id;
        busy_d      = busy;
        timeout_d   = 1'b0;
        limit_hit   = (hold_q == HOLD_LIM);
        release_req = done || !req[grant_id];

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    id_d    = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    grant_d = '0;
                    id_d    = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_req || limit_hit) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    id_d      = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    // Next search starts just after the releasing grantee.
                    ptr_d     = {grant[N-2:0], grant[N-1]};
                    timeout_d = limit_hit && !release_req;
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            ptr_q    <= PTR_INIT;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            ptr_q    <= ptr_d;
            grant    <= grant_d;
            grant_id <= id_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ring_arbiter.sv
// Scoreboard bench for ring_arbiter: an index-based reference model predicts
// each cycle's outputs, and a monitor compares them against the DUT.
module tb_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int IW       = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          timeout;

    ring_arbiter #(
        .N(N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  g;
        logic          b;
        logic          t;
        logic [IW-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Reference model: owner index (-1 = none), cycles held, next priority index.
    int m_owner = -1;
    int m_held  = 0;
    int m_prio  = 0;
    bit m_to    = 1'b0;

    initial begin
        exp_t e;
        bit   lim;
        bit   drop;
        forever begin
            @(posedge clk);
            cycle++;
            if (reset) begin
                m_owner = -1;
                m_held  = 0;
                m_prio  = 0;
                m_to    = 1'b0;
            end else if (m_owner < 0) begin
                m_to = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && req[(m_prio + k) % N]) begin
                        m_owner = (m_prio + k) % N;
                        m_held  = 1;
                    end
                end
            end else begin
                lim  = (m_held == MAX_HOLD);
                drop = !req[m_owner];
                if (done || drop || lim) begin
                    m_to    = lim && !done && !drop;
                    m_prio  = (m_owner + 1) % N;
                    m_owner = -1;
                    m_held  = 0;
                end else begin
                    m_held++;
                    m_to = 1'b0;
                end
            end
            e.g  = (m_owner >= 0) ? 4'(1 << m_owner) : '0;
            e.b  = (m_owner >= 0);
            e.t  = m_to;
            e.id = (m_owner >= 0) ? IW'(m_owner) : '0;
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (grant !== e.g || busy !== e.b || timeout !== e.t ||
                    (e.b && grant_id !== e.id)) begin
                    errors++;
                    $display("FAIL cycle_%0d: grant=%b busy=%b timeout=%b id=%0d, required grant=%b busy=%b timeout=%b id=%0d",
                             cycle, grant, busy, timeout, grant_id, e.g, e.b, e.t, e.id);
                end
            end
        end
    end

    initial begin
        bit did_reset;
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle with no requests.
        repeat (5) @(negedge clk);

        // All requesting, each grantee finishes in its 2nd grant cycle.
        req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            done = (m_owner >= 0 && m_held == 2);
            @(negedge clk);
        end
        done = 1'b0;

        // Single requester hogging the resource until the hold limit.
        req = 4'b0100;
        repeat (40) @(negedge clk);

        // done coinciding with the hold limit.
        req = 4'b0011;
        for (int i = 0; i < 45; i++) begin
            done = (m_owner >= 0 && m_held == MAX_HOLD);
            @(negedge clk);
        end
        done = 1'b0;

        // Grantee 0 withdraws in its 3rd grant cycle.
        for (int i = 0; i < 25; i++) begin
            req = (m_owner == 0 && m_held == 3) ? 4'b1000 : 4'b1001;
            @(negedge clk);
        end

        // Reset in the 5th cycle of a grant.
        req = 4'b0110;
        did_reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            reset = (!did_reset && m_owner >= 0 && m_held == 5);
            if (reset) did_reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            done  = ($urandom_range(7) == 0);
            reset = ($urandom_range(199) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        done  = 1'b0;
        req   = '0;

        repeat (3) @(negedge clk);
        #1;
        if (checks < 12) begin
            errors++;
            $display("FAIL check_count: made %0d, required at least 12", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
